// File: rtl/ros_meas_pkg.sv
// Shared definitions for ring-oscillator measurement blocks: default widths
// and the measurement FSM state encoding.
package ros_meas_pkg;

    localparam int unsigned DEF_DIV_LOG2    = 4;
    localparam int unsigned DEF_GATE_W      = 16;
    localparam int unsigned DEF_CNT_W       = 16;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE,
        DONE
    } meas_state_e;

endpackage

// File: rtl/ros_prescaler.sv
// ro_clk-domain divider; the only logic clocked by the oscillator.
// Only msb_o leaves this domain.
module ros_prescaler
    import ros_meas_pkg::*;
#(
    parameter int unsigned DIV_LOG2 = DEF_DIV_LOG2
) (
    input  logic ro_clk_i,
    input  logic reset_i,
    output logic msb_o
);

    logic                rst_cap_q;
    logic [DIV_LOG2-1:0] div_q;
    logic [DIV_LOG2-1:0] div_d;

    always_comb begin
        div_d = div_q + 1'b1;
    end

    // reset_i is clk-domain; one capture flop re-times it before it clears the divider
    always_ff @(posedge ro_clk_i) begin
        rst_cap_q <= reset_i;
        if (rst_cap_q) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign msb_o = div_q[DIV_LOG2-1];

endmodule

// File: rtl/ros_freq_counter.sv
// Counts prescaled ring-oscillator edges over a window of gate_len clk cycles.
// Prescaler MSB is synchronized into clk, edge-detected and counted by a small FSM.
module ros_freq_counter
    import ros_meas_pkg::*;
#(
    parameter int unsigned DIV_LOG2    = DEF_DIV_LOG2,
    parameter int unsigned GATE_W      = DEF_GATE_W,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ro_clk,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_len,
    output logic              busy,
    output logic              valid,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    logic                   ro_msb;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   prev_q, prev_d;
    logic                   rise;
    meas_state_e            state_q, state_d;
    logic [GATE_W-1:0]      gate_q, gate_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   ovf_q, ovf_d;

    ros_prescaler #(
        .DIV_LOG2(DIV_LOG2)
    ) u_prescaler (
        .ro_clk_i(ro_clk),
        .reset_i (reset),
        .msb_o   (ro_msb)
    );

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            state_q <= IDLE;
            gate_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], ro_msb};
            prev_q  <= prev_d;
            state_q <= state_d;
            gate_q  <= gate_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        // prev tracks synced every cycle, so the ARM cycle always primes it
        // and a level already high at window start is never seen as an edge
        prev_d  = synced;
        rise    = synced & ~prev_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    gate_d  = gate_len;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = (gate_len == '0) ? DONE : ARM;
                end
            end
            ARM: begin
                state_d = MEASURE;
            end
            MEASURE: begin
                gate_d = gate_q - 1'b1;
                if (rise) begin
                    if (count_q == '1) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                if (gate_q == GATE_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy     = (state_q == ARM) || (state_q == MEASURE);
    assign valid    = (state_q == DONE);
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_ros_freq_counter.sv
// Directed bench for ros_freq_counter: a 16-bit and a 4-bit counter instance share stimulus.
`timescale 1ns/1ps
module tb_ros_freq_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ro_clk = 1'b0;
    logic        ro_en = 1'b1;
    real         ro_half = 1.25;
    logic        start = 1'b0;
    logic [15:0] gate_len = '0;

    logic        busy, valid, overflow;
    logic [15:0] count;
    logic        busy4, valid4, overflow4;
    logic [3:0]  count4;

    int n_chk = 0;
    int n_fail = 0;

    ros_freq_counter #(.DIV_LOG2(4), .GATE_W(16), .CNT_W(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .ro_clk(ro_clk), .start(start), .gate_len(gate_len),
        .busy(busy), .valid(valid), .count(count), .overflow(overflow)
    );

    ros_freq_counter #(.DIV_LOG2(4), .GATE_W(16), .CNT_W(4), .SYNC_STAGES(2)) dut4 (
        .clk(clk), .reset(reset), .ro_clk(ro_clk), .start(start), .gate_len(gate_len),
        .busy(busy4), .valid(valid4), .count(count4), .overflow(overflow4)
    );

    always #5 clk = ~clk;

    always begin
        if (ro_en) begin
            #(ro_half);
            ro_clk = ~ro_clk;
        end else begin
            ro_clk = 1'b0;
            #1;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string name, input int act, input int exp, input int tol);
        n_chk++;
        if (act < exp - tol || act > exp + tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    // Runs one measurement; lat is the cycle (start cycle = 0) on which valid is seen.
    task automatic run_meas(input int n, output int lat, output int cnt, output int ovf,
                            output int cnt4, output int ovf4, output int v4,
                            output int busy_ok, output int vdrop);
        start = 1'b1;
        gate_len = n[15:0];
        tick();
        start = 1'b0;
        lat = -1; cnt = -1; ovf = -1; cnt4 = -1; ovf4 = -1; v4 = 0;
        busy_ok = 1; vdrop = 1;
        for (int c = 1; c <= n + 20; c++) begin
            if (valid) begin
                lat = c;
                cnt = int'(count);
                ovf = int'(overflow);
                cnt4 = int'(count4);
                ovf4 = int'(overflow4);
                v4 = int'(valid4);
                if (busy) busy_ok = 0;
                break;
            end
            if (!busy) busy_ok = 0;
            tick();
        end
        tick();
        vdrop = int'(valid);
    endtask

    typedef struct {
        int  gate;
        real half;
        int  settle;
        int  lat;
        int  cnt, tol, ovf;
        int  cnt4, tol4, ovf4;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int lat, cnt, ovf, cnt4, ovf4, v4, busy_ok, vdrop;
        int vcount, vcycle, busy103;

        vecs[0] = '{gate: 400,  half: 1.25, settle: 20,  lat: 402,  cnt: 100, tol: 1, ovf: 0, cnt4: 15, tol4: 0, ovf4: 1};
        vecs[1] = '{gate: 0,    half: 1.25, settle: 5,   lat: 1,    cnt: 0,   tol: 0, ovf: 0, cnt4: 0,  tol4: 0, ovf4: 0};
        vecs[2] = '{gate: 40,   half: 1.25, settle: 5,   lat: 42,   cnt: 10,  tol: 1, ovf: 0, cnt4: 10, tol4: 1, ovf4: 0};
        vecs[3] = '{gate: 1024, half: 80.0, settle: 600, lat: 1026, cnt: 4,   tol: 1, ovf: 0, cnt4: 4,  tol4: 1, ovf4: 0};

        reset = 1'b1;
        ticks(5);
        chk("reset_busy", int'(busy), 0, 0);
        chk("reset_valid", int'(valid), 0, 0);
        chk("reset_count", int'(count), 0, 0);
        chk("reset_overflow", int'(overflow), 0, 0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            ro_half = vecs[i].half;
            ticks(vecs[i].settle);
            run_meas(vecs[i].gate, lat, cnt, ovf, cnt4, ovf4, v4, busy_ok, vdrop);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat, 0);
            chk($sformatf("v%0d_count", i), cnt, vecs[i].cnt, vecs[i].tol);
            chk($sformatf("v%0d_overflow", i), ovf, vecs[i].ovf, 0);
            chk($sformatf("v%0d_count4", i), cnt4, vecs[i].cnt4, vecs[i].tol4);
            chk($sformatf("v%0d_overflow4", i), ovf4, vecs[i].ovf4, 0);
            chk($sformatf("v%0d_valid4", i), v4, 1, 0);
            chk($sformatf("v%0d_busy_window", i), busy_ok, 1, 0);
            chk($sformatf("v%0d_valid_one_cycle", i), vdrop, 0, 0);
        end

        // Reset asserted on cycle 50 of a 400-cycle window
        ro_half = 1.25;
        ticks(20);
        start = 1'b1;
        gate_len = 16'd400;
        tick();
        start = 1'b0;
        ticks(49);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset_busy", int'(busy), 0, 0);
        chk("midreset_count", int'(count), 0, 0);
        chk("midreset_overflow", int'(overflow), 0, 0);
        chk("midreset_valid", int'(valid), 0, 0);
        vcount = 0;
        for (int c = 0; c < 450; c++) begin
            if (valid) vcount++;
            tick();
        end
        chk("midreset_no_valid", vcount, 0, 0);
        run_meas(40, lat, cnt, ovf, cnt4, ovf4, v4, busy_ok, vdrop);
        chk("postreset_latency", lat, 42, 0);
        chk("postreset_count", cnt, 10, 1);
        chk("postreset_overflow", ovf, 0, 0);

        // Stopped oscillator; extra starts on cycles 10, 101 (MEASURE) and 102 (DONE)
        ro_en = 1'b0;
        ticks(30);
        start = 1'b1;
        gate_len = 16'd100;
        tick();
        start = 1'b0;
        vcount = 0;
        vcycle = -1;
        busy103 = -1;
        for (int c = 1; c <= 150; c++) begin
            if (valid) begin
                vcount++;
                if (vcycle < 0) vcycle = c;
            end
            if (c == 103) busy103 = int'(busy);
            start = (c == 10 || c == 101 || c == 102);
            gate_len = 16'd7;
            tick();
        end
        start = 1'b0;
        chk("stopped_valid_pulses", vcount, 1, 0);
        chk("stopped_valid_cycle", vcycle, 102, 0);
        chk("stopped_count", int'(count), 0, 0);
        chk("stopped_overflow", int'(overflow), 0, 0);
        chk("start_in_done_ignored", busy103, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
